// File: rtl/pool_layer_generic.sv
// Streaming max/average pooling over non-overlapping POOL_SIZE x POOL_SIZE windows of a
// channel-major raster; trailing rows/columns that do not fill a window are cropped.
module pool_layer_generic #(
    parameter int IMG_SIZE   = 10,
    parameter int CHANNELS   = 3,
    parameter int POOL_SIZE  = 2,
    parameter int DATA_WIDTH = 16,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_pool,
    input  logic                         mode,
    input  logic                         data_valid,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic                         busy,
    output logic                         result_valid,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic [CH_W-1:0]              result_channel,
    output logic                         finish_pool,
    output logic [1:0]                   dbg_state
);

    localparam int OUT_DIM = IMG_SIZE / POOL_SIZE;
    localparam int LOG_P   = $clog2(POOL_SIZE);
    localparam int ACC_W   = DATA_WIDTH + 2 * LOG_P;
    localparam int CW      = $clog2(IMG_SIZE);
    localparam int BW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    localparam logic [CW:0]     CROP     = (CW + 1)'(OUT_DIM * POOL_SIZE);
    localparam logic [CW-1:0]   LAST_POS = CW'(IMG_SIZE - 1);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: there is no ready. In RUN every cycle with data_valid high consumes
    // data_in; result_valid and finish_pool are single-cycle strobes that cannot stall.
    state_t                  state;
    logic [CW-1:0]           col;
    logic [CW-1:0]           row;
    logic [CH_W-1:0]         ch;
    logic                    mode_r;
    logic signed [ACC_W-1:0] acc_buf [OUT_DIM];

    logic [BW-1:0]           idx;
    logic                    in_win;
    logic                    win_first;
    logic                    win_last;
    logic                    last_pix;
    logic signed [ACC_W-1:0] cur;
    logic signed [ACC_W-1:0] pix_ext;
    logic signed [ACC_W-1:0] upd;
    logic signed [ACC_W-1:0] avg;

    assign dbg_state = state;

    always_comb begin
        idx       = BW'(col >> LOG_P);
        in_win    = ({1'b0, col} < CROP) && ({1'b0, row} < CROP);
        win_first = (col[LOG_P-1:0] == '0) && (row[LOG_P-1:0] == '0);
        win_last  = (&col[LOG_P-1:0]) && (&row[LOG_P-1:0]);
        last_pix  = (col == LAST_POS) && (row == LAST_POS) && (ch == LAST_CH);
        cur       = acc_buf[idx];
        pix_ext   = {{(ACC_W - DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};
        if (win_first) begin
            upd = pix_ext;
        end else if (mode_r) begin
            upd = cur + pix_ext;
        end else begin
            upd = (pix_ext > cur) ? pix_ext : cur;
        end
        // Arithmetic shift floors the mean, so negative averages round toward -inf.
        avg = upd >>> (2 * LOG_P);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            result_valid   <= 1'b0;
            finish_pool    <= 1'b0;
            data_out       <= '0;
            result_channel <= '0;
            col            <= '0;
            row            <= '0;
            ch             <= '0;
            mode_r         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            finish_pool  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_pool) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        col    <= '0;
                        row    <= '0;
                        ch     <= '0;
                        mode_r <= mode;
                    end
                end
                RUN: begin
                    if (data_valid) begin
                        if (in_win) begin
                            acc_buf[idx] <= upd;
                            if (win_last) begin
                                result_valid   <= 1'b1;
                                data_out       <= mode_r ? avg[DATA_WIDTH-1:0] : upd[DATA_WIDTH-1:0];
                                result_channel <= ch;
                            end
                        end
                        if (col == LAST_POS) begin
                            col <= '0;
                            if (row == LAST_POS) begin
                                row <= '0;
                                ch  <= (ch == LAST_CH) ? '0 : ch + 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (last_pix) begin
                            state       <= DONE;
                            finish_pool <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool_layer_generic.sv
// Directed bench for pool_layer_generic: four configurations share the input stimulus,
// only the instance given a start_pool runs; outputs are scored against an expected queue.
module tb_pool_layer_generic;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               mode;
    logic               data_valid;
    logic signed [15:0] data_in;
    logic [3:0]         start;

    wire [3:0]          busy_v;
    wire [3:0]          rv_v;
    wire [3:0]          fin_v;
    wire signed [15:0]  dout_v [4];
    wire [1:0]          rch_v [4];
    wire [1:0]          st_v [4];

    assign rch_v[1][1] = 1'b0;
    assign rch_v[2][1] = 1'b0;
    assign rch_v[3][1] = 1'b0;

    pool_layer_generic #(.IMG_SIZE(10), .CHANNELS(3), .POOL_SIZE(2), .DATA_WIDTH(16)) u_def (
        .clk(clk), .reset(reset), .start_pool(start[0]), .mode(mode), .data_valid(data_valid),
        .data_in(data_in), .busy(busy_v[0]), .result_valid(rv_v[0]), .data_out(dout_v[0]),
        .result_channel(rch_v[0]), .finish_pool(fin_v[0]), .dbg_state(st_v[0]));

    pool_layer_generic #(.IMG_SIZE(4), .CHANNELS(1), .POOL_SIZE(2), .DATA_WIDTH(16)) u_avg4 (
        .clk(clk), .reset(reset), .start_pool(start[1]), .mode(mode), .data_valid(data_valid),
        .data_in(data_in), .busy(busy_v[1]), .result_valid(rv_v[1]), .data_out(dout_v[1]),
        .result_channel(rch_v[1][0]), .finish_pool(fin_v[1]), .dbg_state(st_v[1]));

    pool_layer_generic #(.IMG_SIZE(5), .CHANNELS(2), .POOL_SIZE(2), .DATA_WIDTH(16)) u_crop (
        .clk(clk), .reset(reset), .start_pool(start[2]), .mode(mode), .data_valid(data_valid),
        .data_in(data_in), .busy(busy_v[2]), .result_valid(rv_v[2]), .data_out(dout_v[2]),
        .result_channel(rch_v[2][0]), .finish_pool(fin_v[2]), .dbg_state(st_v[2]));

    pool_layer_generic #(.IMG_SIZE(8), .CHANNELS(1), .POOL_SIZE(4), .DATA_WIDTH(16)) u_p4 (
        .clk(clk), .reset(reset), .start_pool(start[3]), .mode(mode), .data_valid(data_valid),
        .data_in(data_in), .busy(busy_v[3]), .result_valid(rv_v[3]), .data_out(dout_v[3]),
        .result_channel(rch_v[3][0]), .finish_pool(fin_v[3]), .dbg_state(st_v[3]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard
    logic [15:0] exp_q[$];
    logic [1:0]  exp_ch_q[$];
    int          act = 0;
    int          exp_tot [4] = '{0, 0, 0, 0};
    int          got_cnt [4] = '{0, 0, 0, 0};
    int          fin_cyc [4] = '{-1, -1, -1, -1};
    logic        fin_rv  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int          last_acc = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rv_v[i] === 1'b1) got_cnt[i]++;
            if (fin_v[i] === 1'b1) begin
                fin_cyc[i] = cyc;
                fin_rv[i]  = rv_v[i];
            end
        end
        if (rv_v[act] === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", got_cnt[act], exp_tot[act]);
            end else begin
                chk("data_out", $signed(dout_v[act]), $signed(exp_q.pop_front()));
                chk("result_channel", rch_v[act], exp_ch_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int v, input int c);
        exp_q.push_back(16'(v));
        exp_ch_q.push_back(2'(c));
        exp_tot[act]++;
    endtask

    task automatic start_run(input int i, input logic m);
        act      = i;
        mode     = m;
        start[i] = 1'b1;
        tick();
        start    = '0;
        mode     = ~m;
        chk("busy_after_start", busy_v[i], 1);
    endtask

    task automatic pix(input logic signed [15:0] v, input int gap);
        data_in    = v;
        data_valid = 1'b1;
        tick();
        last_acc   = cyc;
        data_valid = 1'b0;
        data_in    = 16'(int'($urandom_range(0, 65535)));
        repeat (gap) tick();
    endtask

    task automatic check_end(input int i, input int n_out, input int base, input logic coincide);
        chk("finish_pool_high", fin_v[i], 1);
        chk("busy_at_finish", busy_v[i], 1);
        tick();
        chk("busy_after_finish", busy_v[i], 0);
        chk("finish_pool_low", fin_v[i], 0);
        chk("state_idle", st_v[i], 0);
        tick();
        chk("finish_latency", fin_cyc[i], last_acc);
        chk("finish_with_result", fin_rv[i], coincide);
        chk("out_count", got_cnt[i] - base, n_out);
        chk("exp_left", exp_q.size(), 0);
    endtask

    logic signed [15:0] rimg [64];
    logic signed [15:0] avg_img [16] = '{-3, -2, 8191, 8191,  -2, -2, 8191, 8191,
                                         1, 2, -1, 0,  3, 4, 0, 0};

    initial begin
        int base;
        int s;
        logic signed [15:0] v;

        reset = 1'b1; start = '0; mode = 1'b0; data_valid = 1'b0; data_in = '0;
        tick();
        data_valid = 1'b1;
        start      = 4'hf;
        tick();
        start      = '0;
        data_valid = 1'b0;
        for (int i = 0; i < 4; i++) chk("reset_busy", busy_v[i], 0);
        chk("reset_result_valid", rv_v, 0);
        chk("reset_finish", fin_v, 0);
        chk("reset_data_out", dout_v[0], 0);
        chk("reset_channel", rch_v[0], 0);
        chk("reset_state", st_v[0], 0);
        reset = 1'b0;
        tick();

        // data_valid while every instance is idle
        for (int k = 0; k < 5; k++) pix(16'sd32767, 0);
        tick();
        chk("idle_busy", busy_v, 0);
        chk("idle_outputs", got_cnt[0] + got_cnt[1] + got_cnt[2] + got_cnt[3], 0);

        // Average, 4x4x1, with a start_pool pulsed mid-run
        act = 1;
        push_exp(-3, 0); push_exp(8191, 0); push_exp(2, 0); push_exp(-1, 0);
        base = got_cnt[1];
        start_run(1, 1'b1);
        for (int k = 0; k < 16; k++) begin
            if (k == 6) start[1] = 1'b1;
            pix(avg_img[k], 0);
            start = '0;
        end
        check_end(1, 4, base, 1'b1);

        // Max, defaults, ramp
        act = 0;
        for (int c = 0; c < 3; c++)
            for (int wr = 0; wr < 5; wr++)
                for (int wc = 0; wc < 5; wc++)
                    push_exp(c * 100 + (2 * wr + 1) * 10 + 2 * wc + 1 - 150, c);
        base = got_cnt[0];
        start_run(0, 1'b0);
        for (int k = 0; k < 300; k++) pix(16'(k - 150), 0);
        check_end(0, 75, base, 1'b1);

        // Crop: 5x5x2, last row and column hold 32767
        act = 2;
        push_exp(6, 0); push_exp(8, 0); push_exp(16, 0); push_exp(18, 0);
        push_exp(0, 1); push_exp(-2, 1); push_exp(-10, 1); push_exp(-12, 1);
        base = got_cnt[2];
        start_run(2, 1'b0);
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 5; r++)
                for (int cl = 0; cl < 5; cl++) begin
                    if (r == 4 || cl == 4) v = 16'sd32767;
                    else v = (c == 0) ? 16'(r * 5 + cl) : 16'(-(r * 5 + cl));
                    pix(v, 0);
                end
        check_end(2, 8, base, 1'b0);

        // POOL_SIZE 4, average of random data, valid every other cycle
        act = 3;
        for (int k = 0; k < 64; k++) rimg[k] = 16'($urandom_range(0, 65535));
        for (int wr = 0; wr < 2; wr++)
            for (int wc = 0; wc < 2; wc++) begin
                s = 0;
                for (int r = 0; r < 4; r++)
                    for (int cl = 0; cl < 4; cl++)
                        s += int'(rimg[(wr * 4 + r) * 8 + wc * 4 + cl]);
                push_exp(s >>> 4, 0);
            end
        base = got_cnt[3];
        start_run(3, 1'b1);
        for (int k = 0; k < 64; k++) pix(rimg[k], (k == 63) ? 0 : 1);
        check_end(3, 4, base, 1'b1);

        // Reset after 100 pixels, then restart in average mode
        act = 0;
        for (int wr = 0; wr < 5; wr++)
            for (int wc = 0; wc < 5; wc++)
                push_exp((2 * wr + 1) * 10 + 2 * wc + 1 - 150, 0);
        base = got_cnt[0];
        start_run(0, 1'b0);
        for (int k = 0; k < 100; k++) pix(16'(k - 150), 0);
        tick();
        chk("pre_reset_count", got_cnt[0] - base, 25);
        reset    = 1'b1;
        start[0] = 1'b1;
        tick();
        reset    = 1'b0;
        start    = '0;
        chk("reset_mid_busy", busy_v[0], 0);
        chk("reset_mid_state", st_v[0], 0);
        chk("reset_mid_data_out", dout_v[0], 0);
        base = got_cnt[0];
        for (int k = 0; k < 10; k++) pix(16'sd1000, 0);
        tick();
        chk("after_reset_outputs", got_cnt[0] - base, 0);
        for (int c = 0; c < 3; c++)
            for (int wr = 0; wr < 5; wr++)
                for (int wc = 0; wc < 5; wc++)
                    push_exp(c * 100 + 20 * wr + 2 * wc - 150 + 5, c);
        start_run(0, 1'b1);
        for (int k = 0; k < 300; k++) pix(16'(k - 150), 0);
        check_end(0, 75, base, 1'b1);

        chk("total_def", got_cnt[0], 175);
        chk("total_avg4", got_cnt[1], 4);
        chk("total_crop", got_cnt[2], 8);
        chk("total_p4", got_cnt[3], 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
